// File: rtl/conv_input_buffer_writer_pkg.sv
// Shared types and constants for the convolution input buffer writer.
// Address-queue entry layout and controller state encoding live here.
package conv_input_buffer_writer_pkg;

  localparam logic [15:0] BUF_ADR_NONE = 16'hffff;
  localparam int DDR_WORD_WIDTH = 256;
  localparam int BUFFERS_NUM = 3;
  localparam int INPUT_BUFFER_SIZE_2POW = 12;
  localparam int ADR_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [15:0] adr;
    logic [1:0]  idx;
    logic        word_select;
    logic        valid;
  } adr_entry_t;

  // A queued entry carries a real write only if flagged valid
  // and not the "no address" marker used for padding rows.
  function automatic logic entry_live(adr_entry_t e);
    return e.valid && (e.adr != BUF_ADR_NONE);
  endfunction

endpackage

// File: rtl/conv_input_buffer_writer_if.sv
// DDR input-word stream: valid/ready handshake with one word per beat.
// The DDR read channel is the master, the buffer writer the slave.
interface conv_input_buffer_writer_if
  import conv_input_buffer_writer_pkg::*;
#(
  parameter int W = DDR_WORD_WIDTH
);

  logic [W-1:0] ddr_data;
  logic         ddr_valid;
  logic         ddr_ready;

  modport master (
    output ddr_data,
    output ddr_valid,
    input  ddr_ready
  );

  modport slave (
    input  ddr_data,
    input  ddr_valid,
    output ddr_ready
  );

endinterface

// File: rtl/conv_adr_fifo.sv
// Small synchronous queue of buffer-address entries.
// Same-cycle push and pop keep the count unchanged.
module conv_adr_fifo
  import conv_input_buffer_writer_pkg::*;
#(
  parameter int DEPTH = ADR_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  adr_entry_t din,
  input  logic       pop,
  output adr_entry_t dout,
  output logic [AW:0] count,
  output logic       full,
  output logic       empty
);

  adr_entry_t mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic do_push;
  logic do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  // Entry storage, no reset needed: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_input_buffer_writer.sv
// Paces the input-load controller, queues its addresses and writes
// each DDR input word into the selected row buffer bank and half.
module conv_input_buffer_writer
  import conv_input_buffer_writer_pkg::*;
#(
  parameter int ddr_word_width = DDR_WORD_WIDTH,
  parameter int buffers_num = BUFFERS_NUM,
  parameter int input_buffer_size_2pow = INPUT_BUFFER_SIZE_2POW,
  parameter int adr_fifo_depth = ADR_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic conv_load_input,
  input  logic [15:0] row1_buf_adr,
  input  logic [1:0]  row1_buf_idx,
  input  logic row1_buf_word_select,
  input  logic valid_row1_adr,
  input  logic conv_end,
  conv_input_buffer_writer_if.slave ddr,
  output logic [buffers_num-1:0] buf_we,
  output logic [input_buffer_size_2pow-1:0] buf_wadr,
  output logic [2*ddr_word_width-1:0] buf_wdata,
  output logic [1:0] buf_wmask,
  output logic busy,
  output logic done,
  output logic adr_overflow
);

  localparam int CW = $clog2(adr_fifo_depth) + 1;
  localparam int AB = input_buffer_size_2pow;

  state_t state;
  state_t state_nx;

  adr_entry_t push_e;
  adr_entry_t head;
  logic [CW-1:0] count;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_live;
  logic accept;
  logic hi_bad;
  logic idx_bad;
  logic [buffers_num-1:0] we_nx;

  assign push_e = '{
    adr:         row1_buf_adr,
    idx:         row1_buf_idx,
    word_select: row1_buf_word_select,
    valid:       valid_row1_adr
  };

  assign head_live = entry_live(head);

  assign conv_load_input =
    (state == ISSUE) && (count < CW'(adr_fifo_depth));
  assign push = conv_load_input && !full;

  assign ddr.ddr_ready = !empty && head_live;
  assign accept = ddr.ddr_valid && ddr.ddr_ready;

  // Padding entries leave at once; real ones wait for a DDR word.
  assign pop = !empty && (!head_live || ddr.ddr_valid);

  assign hi_bad  = |head.adr[15:AB];
  assign idx_bad = int'(head.idx) >= buffers_num;

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);

  conv_adr_fifo #(
    .DEPTH (adr_fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_e),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: the conv_end push is the last one of the layer.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: if (push && conv_end) state_nx = DRAIN;
      DRAIN: if (empty) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One-hot bank decode; an out-of-range index selects nothing.
  always_comb begin
    we_nx = '0;
    for (int b = 0; b < buffers_num; b++) begin
      if (int'(head.idx) == b) we_nx[b] = 1'b1;
    end
  end

  // Write register: one buffer write the cycle after each accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_we    <= '0;
      buf_wadr  <= '0;
      buf_wdata <= '0;
      buf_wmask <= '0;
    end else begin
      buf_we    <= '0;
      buf_wmask <= '0;
      if (accept) begin
        buf_we    <= we_nx;
        buf_wadr  <= head.adr[AB-1:0];
        buf_wdata <= {2{ddr.ddr_data}};
        buf_wmask <= head.word_select ? 2'b10 : 2'b01;
      end
    end
  end

  // Sticky flag for addresses or banks outside the buffers.
  always_ff @(posedge clk) begin
    if (!reset) adr_overflow <= 1'b0;
    else if (accept && (hi_bad || idx_bad)) adr_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_conv_input_buffer_writer.sv
// Randomized bench for conv_input_buffer_writer with an in-order
// entry/word pairing model and directed boundary scenarios.
module tb_conv_input_buffer_writer;
  import conv_input_buffer_writer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic conv_load_input;
  logic [15:0] row1_buf_adr;
  logic [1:0] row1_buf_idx;
  logic row1_buf_word_select;
  logic valid_row1_adr;
  logic conv_end;
  logic [2:0] buf_we;
  logic [11:0] buf_wadr;
  logic [511:0] buf_wdata;
  logic [1:0] buf_wmask;
  logic busy;
  logic done;
  logic adr_overflow;

  conv_input_buffer_writer_if ddr_if ();

  conv_input_buffer_writer dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .conv_load_input      (conv_load_input),
    .row1_buf_adr         (row1_buf_adr),
    .row1_buf_idx         (row1_buf_idx),
    .row1_buf_word_select (row1_buf_word_select),
    .valid_row1_adr       (valid_row1_adr),
    .conv_end             (conv_end),
    .ddr                  (ddr_if),
    .buf_we               (buf_we),
    .buf_wadr             (buf_wadr),
    .buf_wdata            (buf_wdata),
    .buf_wmask            (buf_wmask),
    .busy                 (busy),
    .done                 (done),
    .adr_overflow         (adr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] adr;
    logic [1:0]  idx;
    logic        ws;
    logic        vld;
  } ent_t;

  typedef struct {
    logic [2:0]   we;
    logic [11:0]  wadr;
    logic [511:0] wdata;
    logic [1:0]   wmask;
  } wr_t;

  ent_t ents[$];
  wr_t  expq[$];

  int n_chk = 0;
  int n_pass = 0;
  int k, pushes, accepts, writes, vp, cyc, done_cnt;
  int first_push, first_write, last_write, done_cyc;
  int dv_pct;
  logic ov_exp;
  logic st;
  logic load_active;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic live(ent_t e);
    return e.vld && (e.adr != 16'hffff);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic ent_t mk(int adr, int idx, int ws, int vld);
    ent_t e;
    e.adr = adr[15:0];
    e.idx = idx[1:0];
    e.ws  = ws[0];
    e.vld = vld[0];
    return e;
  endfunction

  // One clock cycle: drive at negedge, observe after posedge.
  task automatic tick();
    ent_t e;
    wr_t w;
    logic push;
    logic acc;
    start = st;
    st = 1'b0;
    if (k < ents.size()) begin
      e = ents[k];
      row1_buf_adr = e.adr;
      row1_buf_idx = e.idx;
      row1_buf_word_select = e.ws;
      valid_row1_adr = e.vld;
      conv_end = (k == ents.size() - 1);
    end else begin
      row1_buf_adr = 16'hffff;
      row1_buf_idx = 2'd0;
      row1_buf_word_select = 1'b0;
      valid_row1_adr = 1'b0;
      conv_end = 1'b0;
    end
    ddr_if.ddr_valid = ($urandom_range(99) < dv_pct);
    ddr_if.ddr_data = rand256();
    #1;
    push = conv_load_input;
    acc = ddr_if.ddr_valid && ddr_if.ddr_ready;
    if (acc) begin
      accepts++;
      while (vp < k && !live(ents[vp])) vp++;
      if (vp < k) begin
        e = ents[vp];
        vp++;
        w.we = (e.idx < 2'd3) ? (3'b001 << e.idx) : 3'b000;
        w.wadr = e.adr[11:0];
        w.wdata = {2{ddr_if.ddr_data}};
        w.wmask = e.ws ? 2'b10 : 2'b01;
        if (e.adr[15:12] != 4'd0 || e.idx >= 2'd3) ov_exp = 1'b1;
        expq.push_back(w);
      end else begin
        chk("spurious_ready", 1, 0);
      end
    end
    if (push) begin
      if (pushes == 0) first_push = cyc;
      pushes++;
      if (k < ents.size()) k++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (expq.size() > 0) begin
      w = expq.pop_front();
      chk("buf_we", buf_we, w.we);
      chk("buf_wadr", buf_wadr, w.wadr);
      chk("buf_wdata", buf_wdata, w.wdata);
      chk("buf_wmask", buf_wmask, w.wmask);
      writes++;
      if (writes == 1) first_write = cyc;
      last_write = cyc;
    end else if (buf_we != 3'b000) begin
      chk("spurious_we", buf_we, 0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    chk("busy", busy, load_active && (done_cnt == 0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    st = 1'b0;
    ddr_if.ddr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl",
        {conv_load_input, ddr_if.ddr_ready, buf_we, buf_wmask,
         busy, done, adr_overflow}, 0);
    chk("rst_wadr", buf_wadr, 0);
    chk("rst_wdata", buf_wdata, 0);
    reset = 1'b1;
    ov_exp = 1'b0;
    load_active = 1'b0;
    ents.delete();
    expq.delete();
    k = 0;
    vp = 0;
    pushes = 0;
    accepts = 0;
    writes = 0;
    done_cnt = 0;
  endtask

  task automatic begin_load();
    k = 0;
    vp = 0;
    pushes = 0;
    accepts = 0;
    writes = 0;
    cyc = 0;
    done_cnt = 0;
    first_push = -1;
    first_write = -1;
    last_write = -1;
    done_cyc = -1;
    expq.delete();
    st = 1'b1;
    load_active = 1'b1;
  endtask

  task automatic run_to_done(input int pct);
    dv_pct = pct;
    while (done_cnt == 0 && cyc < 2000) tick();
    chk("done_seen", done_cnt > 0, 1);
    dv_pct = 100;
    repeat (2) tick();
  endtask

  task automatic end_checks();
    int nval;
    nval = 0;
    foreach (ents[i]) if (live(ents[i])) nval++;
    chk("first_push_cyc", first_push, 1);
    chk("pushes", pushes, ents.size());
    chk("accepts", accepts, nval);
    chk("writes", writes, nval);
    chk("done_cnt", done_cnt, 1);
    chk("overflow", adr_overflow, ov_exp);
    if (nval > 0 && live(ents[ents.size()-1]))
      chk("done_after_write", done_cyc, last_write + 1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    st = 1'b0;
    dv_pct = 0;
    cyc = 0;
    row1_buf_adr = 16'hffff;
    row1_buf_idx = 2'd0;
    row1_buf_word_select = 1'b0;
    valid_row1_adr = 1'b0;
    conv_end = 1'b0;
    ddr_if.ddr_valid = 1'b0;
    ddr_if.ddr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Four valid entries, DDR always ready with data.
    ents = '{mk(0, 0, 0, 1), mk(1, 1, 1, 1),
             mk(2, 2, 0, 1), mk(3, 0, 1, 1)};
    begin_load();
    run_to_done(100);
    end_checks();
    chk("write_burst", last_write - first_write, 3);

    // Stalled DDR: queue fills, then one accept frees one slot.
    ents.delete();
    for (int i = 0; i < 6; i++) ents.push_back(mk(16 + i, i % 3, i % 2, 1));
    begin_load();
    dv_pct = 0;
    repeat (10) tick();
    chk("strobes_stall", pushes, 4);
    chk("strobe_low", conv_load_input, 0);
    dv_pct = 100;
    tick();
    dv_pct = 0;
    repeat (4) tick();
    chk("strobes_one_more", pushes, 5);
    chk("accepts_one", accepts, 1);
    run_to_done(100);
    end_checks();

    // Padding entries in the middle never touch DDR.
    ents = '{mk(40, 1, 0, 1), mk(16'hffff, 2, 1, 1),
             mk(41, 0, 1, 0), mk(42, 2, 1, 1)};
    begin_load();
    run_to_done(100);
    end_checks();

    // Out-of-range address: truncated write, sticky flag.
    ents = '{mk(16'h1005, 1, 0, 1), mk(7, 2, 1, 1)};
    begin_load();
    run_to_done(100);
    end_checks();
    ents = '{mk(9, 0, 0, 1)};
    begin_load();
    run_to_done(70);
    end_checks();
    chk("overflow_sticky", adr_overflow, 1);

    // Out-of-range bank: no enable, flag set.
    do_reset();
    ents = '{mk(8, 3, 0, 1), mk(9, 0, 1, 1)};
    begin_load();
    run_to_done(100);
    end_checks();

    // Single-step layer with start pulsed while busy.
    do_reset();
    ents = '{mk(100, 2, 1, 1)};
    begin_load();
    dv_pct = 0;
    repeat (3) tick();
    st = 1'b1;
    tick();
    tick();
    run_to_done(100);
    repeat (3) tick();
    end_checks();

    // Reset with three entries queued: nothing survives.
    ents.delete();
    for (int i = 0; i < 6; i++) ents.push_back(mk(200 + i, 1, 0, 1));
    begin_load();
    dv_pct = 0;
    while (pushes < 3 && cyc < 20) tick();
    chk("queued_three", pushes, 3);
    do_reset();
    dv_pct = 100;
    repeat (6) tick();
    chk("post_rst_strobes", pushes, 0);
    chk("post_rst_writes", writes, 0);
    ents = '{mk(300, 0, 0, 1), mk(301, 1, 1, 1), mk(302, 2, 0, 1)};
    begin_load();
    run_to_done(100);
    end_checks();

    // Randomized layers.
    do_reset();
    for (int t = 0; t < 8; t++) begin
      int n;
      int r;
      n = $urandom_range(16, 1);
      ents.delete();
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(7);
        ents.push_back(mk((r == 0) ? 16'hffff : $urandom_range(4095),
                          $urandom_range(2), $urandom_range(1),
                          (r == 1) ? 0 : 1));
      end
      begin_load();
      run_to_done($urandom_range(100, 20));
      end_checks();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_input_buffer_writer.md
# conv_input_buffer_writer

Downstream companion of the convolution input-load controller: it paces that controller with `conv_load_input` strobes, queues the buffer addresses it produces, and pairs each queued address with one incoming DDR input word. It then writes the word into the selected input row buffer bank, selected half-word, and signals completion of a layer's input load. It sits between the DDR read channel and the three input row buffers.

## Interface
Parameters:
- `ddr_word_width`, 256, bits per DDR input word (32 pixels × 8 bit, one input feature)
- `buffers_num`, 3, number of input row buffer banks
- `input_buffer_size_2pow`, 12, log2 of bank depth in buffer words
- `adr_fifo_depth`, 4, address queue entries (power of 2)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse: begin a layer input load
- `conv_load_input`  out  1  advance strobe to the load controller
- `row1_buf_adr`  in  16  buffer address for the current step; 16'hffff = none
- `row1_buf_idx`  in  2  target bank (0..buffers_num-1)
- `row1_buf_word_select`  in  1  half of the buffer word (feature parity)
- `valid_row1_adr`  in  1  address is valid
- `conv_end`  in  1  current step is the last of the layer
- `ddr_data`  in  ddr_word_width  input word
- `ddr_valid`  in  1  DDR word present
- `ddr_ready`  out  1  DDR word accepted when `ddr_valid` is also high
- `buf_we`  out  buffers_num  one-hot bank write enable
- `buf_wadr`  out  input_buffer_size_2pow  bank write address
- `buf_wdata`  out  2*ddr_word_width  write data
- `buf_wmask`  out  2  half-word enables
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle completion pulse
- `adr_overflow`  out  1  sticky error flag

## Operation
- State machine states:
  - IDLE: `start` → ISSUE. `start` is ignored in every other state.
  - ISSUE: assert `conv_load_input` whenever the queue count is below `adr_fifo_depth`. On each strobe, push {adr, idx, word_select, valid}. A push with `conv_end`=1 → DRAIN (it is the final push).
  - DRAIN: no strobes. When the queue is empty and no write is pending → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Entry validity: the queue head is valid iff `valid_row1_adr`=1 and adr≠16'hffff.
- Invalid head: popped in one cycle. No DDR word is consumed and no write is issued (padding rows).
- Valid head:
  - `ddr_ready`=1. On `ddr_valid`&&`ddr_ready`, pop and register one write.
  - `buf_we`[idx]=1 and `buf_wadr`=adr[input_buffer_size_2pow-1:0].
  - `buf_wdata`={ddr_data, ddr_data}.
  - `buf_wmask`: bit 1 if word_select=1, else bit 0.
- `ddr_ready`=0 when the queue is empty or the head is invalid.
- Address range: if adr[15:input_buffer_size_2pow]≠0 on a valid head, set `adr_overflow` (sticky until reset). The write still proceeds with the truncated address.
- Bank index: idx ≥ buffers_num on a valid head sets `adr_overflow`, and `buf_we` is all zeros for that write.
- `busy`=1 in ISSUE and DRAIN.

## Timing
- Reset values (reset=0 at a clk edge): state IDLE, queue empty, `conv_load_input`, `ddr_ready`, `buf_we`, `buf_wmask`, `busy`, `done`, `adr_overflow` all 0. `buf_wadr` and `buf_wdata` are 0.
- Reset asserted mid-load clears everything. In-flight queue entries are discarded and no write is issued.
- `conv_load_input` and `ddr_ready` are combinational from registered state and queue count. The controller address inputs are sampled in the same cycle as `conv_load_input`.
- Write latency: a buffer write appears on the cycle after the DDR handshake. `buf_we` is high for exactly one cycle per accepted word.
- Simultaneous push and pop: count is unchanged, and a push into a full-but-popping queue is not allowed. The strobe depends only on count < depth.
- Throughput: one push and one pop per cycle sustained.
- Minimum load: `start` at cycle 0, first strobe at cycle 1.
- DRAIN→DONE: one cycle after the last write issues. DONE→IDLE: next cycle.

## Structure
- Shared package holds:
  - constants `BUF_ADR_NONE`=16'hffff, `DDR_WORD_WIDTH`, `BUFFERS_NUM`, `INPUT_BUFFER_SIZE_2POW`;
  - the state enum (IDLE/ISSUE/DRAIN/DONE);
  - the packed address-entry struct {adr[15:0], idx[1:0], word_select, valid}.
- One sub-module: `conv_adr_fifo`, a synchronous FIFO with count, full, empty and same-cycle push/pop. The top holds the FSM, DDR handshake, write register and error flag.

## Test plan
- 4 valid entries (adr 0..3, idx 0,1,2,0, word_select 0,1,0,1), continuous `ddr_valid` → 4 writes on consecutive cycles with `buf_wmask` 01,10,01,10 and matching banks; `done` 1 cycle after the last write.
- `ddr_valid` held low → exactly 4 strobes, then `conv_load_input`=0 until the first DDR accept. One accept → exactly one new strobe.
- Entry with adr=16'hffff between two valid entries → only 2 writes and 2 DDR accepts; the padding entry pops without `ddr_ready`.
- adr=16'h1005, idx=1 → `adr_overflow`=1 and remains set; write to bank 1 at 12'h005.
- `conv_end` on the 1st strobe → exactly one strobe, DRAIN, `done` after one write. `start` during `busy` → no effect.
- Reset=0 while 3 entries are queued → next cycle all outputs are 0 and no write follows. A subsequent `start` runs a clean load.
